// File: rtl/dcache_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dcache_req_arbiter_if
// Purpose  : Bundles the requester-facing and cache-facing signals of the
//            data-cache request arbiter. Member names are given from the
//            arbiter's point of view (i_* flow into it, o_* flow out of it).
// Modports : slave  - the arbiter itself
//            master - the environment (requesters plus data_cache)
// Signals  : i_req/i_req_write/i_addr/i_store_data  requester commands
//            o_req_ready/o_data_valid/o_data          requester responses
//            o_req/o_req_write/o_addr/o_store_data    command to data_cache
//            i_req_ready/i_data_valid/i_data          data_cache responses
// Revision : 1.0 - initial release
// ============================================================================
interface dcache_req_arbiter_if #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32
);
  // Requester side
  logic [NUM_REQ-1:0]           i_req;
  logic [NUM_REQ-1:0]           i_req_write;
  logic [NUM_REQ*ADDR_SIZE-1:0] i_addr;
  logic [NUM_REQ*DATA_SIZE-1:0] i_store_data;
  logic [NUM_REQ-1:0]           o_req_ready;
  logic [NUM_REQ-1:0]           o_data_valid;
  logic [DATA_SIZE-1:0]         o_data;
  // Cache side
  logic                         o_req;
  logic                         o_req_write;
  logic [ADDR_SIZE-1:0]         o_addr;
  logic [DATA_SIZE-1:0]         o_store_data;
  logic                         i_req_ready;
  logic                         i_data_valid;
  logic [DATA_SIZE-1:0]         i_data;

  modport slave (
    input  i_req, i_req_write, i_addr, i_store_data,
    input  i_req_ready, i_data_valid, i_data,
    output o_req_ready, o_data_valid, o_data,
    output o_req, o_req_write, o_addr, o_store_data
  );

  modport master (
    output i_req, i_req_write, i_addr, i_store_data,
    output i_req_ready, i_data_valid, i_data,
    input  o_req_ready, o_data_valid, o_data,
    input  o_req, o_req_write, o_addr, o_store_data
  );
endinterface
`default_nettype wire

// File: rtl/dcache_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dcache_req_arbiter
// Purpose  : Round-robin arbiter sharing the single data_cache request port
//            among NUM_REQ requesters, one outstanding transaction at a time.
//            Captures the winning command, issues it, waits for completion
//            and returns the response as a one-cycle pulse to the owner.
// Ports    : i_aclk   - clock
//            i_areset - asynchronous active-high reset
//            bus      - dcache_req_arbiter_if.slave (requester + cache signals)
// Revision : 1.0 - initial release
// ============================================================================
module dcache_req_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32
) (
  input  logic                    i_aclk,
  input  logic                    i_areset,
  dcache_req_arbiter_if.slave     bus
);

  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [GW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic                 write_q, write_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [DATA_SIZE-1:0] store_q, store_d;
  logic [DATA_SIZE-1:0] data_q, data_d;
  logic [NUM_REQ-1:0]   dvalid_q, dvalid_d;

  logic [GW-1:0]        scan_idx;
  logic [GW-1:0]        winner;
  logic                 found;
  logic [NUM_REQ-1:0]   ready;

  // Rotating priority search starting at rr_ptr; first active requester wins.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = GW'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!found && bus.i_req[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  // Ready is only offered in IDLE; the reset term keeps it low while the
  // async reset is asserted regardless of requester activity.
  always_comb begin
    ready = '0;
    if (state_q == S_IDLE && found && !i_areset) begin
      ready[winner] = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    write_d  = write_q;
    addr_d   = addr_q;
    store_d  = store_q;
    data_d   = data_q;
    dvalid_d = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = winner;
          write_d = bus.i_req_write[winner];
          addr_d  = bus.i_addr[winner*ADDR_SIZE +: ADDR_SIZE];
          store_d = bus.i_store_data[winner*DATA_SIZE +: DATA_SIZE];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.i_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.i_data_valid) begin
          data_d           = bus.i_data;
          dvalid_d[grant_q] = 1'b1;
          rr_ptr_d         = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
          state_d          = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      store_q  <= '0;
      data_q   <= '0;
      dvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      data_q   <= data_d;
      dvalid_q <= dvalid_d;
    end
  end

  assign bus.o_req_ready  = ready;
  assign bus.o_req        = (state_q == S_ISSUE);
  assign bus.o_req_write  = write_q;
  assign bus.o_addr       = addr_q;
  assign bus.o_store_data = store_q;
  assign bus.o_data       = data_q;
  assign bus.o_data_valid = dvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_dcache_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_req_arbiter
// Purpose  : Directed self-checking bench for dcache_req_arbiter (NUM_REQ=2).
//            Plays the requesters and the data_cache by hand.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_req_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dcache_req_arbiter_if #(.NUM_REQ(2), .ADDR_SIZE(32), .DATA_SIZE(32)) bus ();

  dcache_req_arbiter #(.NUM_REQ(2), .ADDR_SIZE(32), .DATA_SIZE(32)) u_dut (
    .i_aclk   (clk),
    .i_areset (rst),
    .bus      (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction for requester g; requests must already be driven.
  // lat = cycles the cache holds off i_req_ready while o_req is high.
  task automatic do_txn(input int g, input logic wr, input logic [31:0] a,
                        input logic [31:0] sd, input int lat, input logic [31:0] rd);
    logic [1:0]  onehot;
    logic [63:0] saved_addr;
    onehot = 2'(1 << g);
    #1;
    chk("ready", 64'(bus.o_req_ready), 64'(onehot));
    step();                                   // accept edge
    saved_addr = bus.i_addr;
    bus.i_addr = ~saved_addr;                 // command must be held stable
    #1;
    chk("issue_req", 64'(bus.o_req), 64'd1);
    chk("issue_addr", 64'(bus.o_addr), 64'(a));
    chk("issue_wr", 64'(bus.o_req_write), 64'(wr));
    chk("issue_rdy_low", 64'(bus.o_req_ready), 64'd0);
    if (wr) chk("issue_sd", 64'(bus.o_store_data), 64'(sd));
    for (int i = 0; i < lat; i++) begin
      step();
      chk("hold_req", 64'(bus.o_req), 64'd1);
      chk("hold_addr", 64'(bus.o_addr), 64'(a));
    end
    bus.i_req_ready = 1'b1;
    step();                                   // -> WAIT
    bus.i_req_ready = 1'b0;
    bus.i_addr = saved_addr;
    #1;
    chk("wait_req", 64'(bus.o_req), 64'd0);
    chk("wait_dv", 64'(bus.o_data_valid), 64'd0);
    bus.i_data = rd;
    bus.i_data_valid = 1'b1;
    step();                                   // completion -> IDLE
    bus.i_data_valid = 1'b0;
    chk("done_dv", 64'(bus.o_data_valid), 64'(onehot));
    chk("done_data", 64'(bus.o_data), 64'(rd));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_req        = 2'b11;
    bus.i_req_write  = '0;
    bus.i_addr       = '0;
    bus.i_store_data = '0;
    bus.i_req_ready  = 1'b0;
    bus.i_data_valid = 1'b0;
    bus.i_data       = '0;

    // Reset with both requesting
    #2;
    chk("rst_ready", 64'(bus.o_req_ready), 64'd0);
    chk("rst_req", 64'(bus.o_req), 64'd0);
    chk("rst_dv", 64'(bus.o_data_valid), 64'd0);
    chk("rst_data", 64'(bus.o_data), 64'd0);
    step();
    step();
    bus.i_req = 2'b00;
    rst = 1'b0;

    // Single read from requester 0, cache stalls 2 cycles
    bus.i_req = 2'b01;
    bus.i_addr[31:0] = 32'h100;
    do_txn(0, 1'b0, 32'h100, 32'h0, 2, 32'hDEADBEEF);
    bus.i_req = 2'b00;
    step();
    chk("pulse_1cyc", 64'(bus.o_data_valid), 64'd0);
    chk("data_hold", 64'(bus.o_data), 64'hDEADBEEF);

    // Write from requester 1 (rr_ptr=1 after previous grant 0)
    bus.i_req = 2'b10;
    bus.i_req_write = 2'b10;
    bus.i_addr[63:32] = 32'h40;
    bus.i_store_data[63:32] = 32'h12345678;
    do_txn(1, 1'b1, 32'h40, 32'h12345678, 0, 32'h0);
    bus.i_req = 2'b00;
    bus.i_req_write = 2'b00;

    // Contention: rr_ptr back to 0, expect 0,1,0,1
    bus.i_addr = {32'h300, 32'h200};
    bus.i_req = 2'b11;
    do_txn(0, 1'b0, 32'h200, 32'h0, 1, 32'hA0);
    do_txn(1, 1'b0, 32'h300, 32'h0, 0, 32'hA1);
    do_txn(0, 1'b0, 32'h200, 32'h0, 2, 32'hA2);
    do_txn(1, 1'b0, 32'h300, 32'h0, 0, 32'hA3);
    bus.i_req = 2'b00;

    // Spurious completion in IDLE
    step();
    bus.i_data = 32'hBAD;
    bus.i_data_valid = 1'b1;
    step();
    bus.i_data_valid = 1'b0;
    chk("spur_idle_dv", 64'(bus.o_data_valid), 64'd0);
    chk("spur_idle_data", 64'(bus.o_data), 64'hA3);
    chk("spur_idle_req", 64'(bus.o_req), 64'd0);
    // Spurious completion in ISSUE
    bus.i_addr[31:0] = 32'h500;
    bus.i_req = 2'b01;
    #1;
    chk("spur_ready", 64'(bus.o_req_ready), 64'd1);
    step();
    bus.i_req = 2'b00;
    bus.i_data_valid = 1'b1;
    step();
    bus.i_data_valid = 1'b0;
    chk("spur_issue_dv", 64'(bus.o_data_valid), 64'd0);
    chk("spur_issue_req", 64'(bus.o_req), 64'd1);
    chk("spur_issue_addr", 64'(bus.o_addr), 64'h500);
    bus.i_req_ready = 1'b1;
    step();
    bus.i_req_ready = 1'b0;
    bus.i_data = 32'h55;
    bus.i_data_valid = 1'b1;
    step();
    bus.i_data_valid = 1'b0;
    chk("spur_done_dv", 64'(bus.o_data_valid), 64'd1);
    chk("spur_done_data", 64'(bus.o_data), 64'h55);

    // Reset while waiting on the cache (rr_ptr is 1 before reset)
    bus.i_addr[31:0] = 32'h600;
    bus.i_req = 2'b01;
    step();
    bus.i_req = 2'b00;
    bus.i_req_ready = 1'b1;
    step();
    bus.i_req_ready = 1'b0;
    chk("r6_wait_req", 64'(bus.o_req), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("r6_ready", 64'(bus.o_req_ready), 64'd0);
    chk("r6_req", 64'(bus.o_req), 64'd0);
    chk("r6_dv", 64'(bus.o_data_valid), 64'd0);
    chk("r6_data", 64'(bus.o_data), 64'd0);
    chk("r6_addr", 64'(bus.o_addr), 64'd0);
    bus.i_req = 2'b11;
    #1;
    chk("r6_ready_forced", 64'(bus.o_req_ready), 64'd0);
    step();
    rst = 1'b0;
    bus.i_req = 2'b00;
    bus.i_data = 32'h77;
    bus.i_data_valid = 1'b1;
    step();
    bus.i_data_valid = 1'b0;
    chk("r6_no_pulse", 64'(bus.o_data_valid), 64'd0);
    chk("r6_no_data", 64'(bus.o_data), 64'd0);
    bus.i_req = 2'b11;
    #1;
    chk("r6_ptr_zero", 64'(bus.o_req_ready), 64'd1);
    bus.i_req = 2'b10;
    bus.i_addr[63:32] = 32'h700;
    do_txn(1, 1'b0, 32'h700, 32'h0, 1, 32'hCAFE);
    bus.i_req = 2'b00;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
